cmd_rx_wrapper: RTL and testbench



---
 rtl/cmd_rx_wrapper.sv | 150 +++++++++++++++
 tb/tb_cmd_rx_wrapper.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_rx_wrapper.sv
`default_nettype none
// ============================================================================
// cmd_rx_wrapper : 8N1 UART receiver assembling two bytes into a 16-bit command
// Revision 1.0
// ============================================================================
module cmd_rx_wrapper #(
  parameter int BAUD_DIV = 2604,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  localparam logic [11:0] BAUD_LOAD = 12'(BAUD_DIV);
  localparam logic [11:0] HALF_LOAD = 12'(HALF_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [0:0] W_HIGH = 1'b0;
  localparam logic [0:0] W_LOW  = 1'b1;

  logic        rx_meta;
  logic        rx_sync;
  logic [1:0]  state;
  logic [11:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic [0:0]  word_state;
  logic [7:0]  hi_byte;

  logic baud_exp;
  logic start_det;
  logic byte_rdy;
  logic frm_bad;

  // Both synchronizer flops preset high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  assign baud_exp  = (baud_cnt == 12'd1);
  assign start_det = (state == S_IDLE) && !rx_sync;
  assign byte_rdy  = (state == S_STOP) && baud_exp && rx_sync;
  assign frm_bad   = (state == S_STOP) && baud_exp && !rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= 12'd0;
      bit_cnt  <= 4'd0;
      shift    <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_sync) begin
            baud_cnt <= HALF_LOAD;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_exp) begin
            if (rx_sync) begin
              state <= S_IDLE;
            end else begin
              baud_cnt <= BAUD_LOAD;
              bit_cnt  <= 4'd0;
              state    <= S_DATA;
            end
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        S_DATA: begin
          if (baud_exp) begin
            shift    <= {rx_sync, shift[7:1]};
            baud_cnt <= BAUD_LOAD;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state <= S_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        S_STOP: begin
          if (baud_exp) begin
            state <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_err <= 1'b0;
    end else begin
      frm_err <= frm_bad;
    end
  end

  // A framing error drops any held high byte so the next byte starts a new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_state <= W_HIGH;
      hi_byte    <= 8'h00;
      cmd        <= 16'h0000;
    end else if (frm_bad) begin
      word_state <= W_HIGH;
    end else if (byte_rdy) begin
      if (word_state == W_HIGH) begin
        hi_byte    <= shift;
        word_state <= W_LOW;
      end else begin
        cmd        <= {hi_byte, shift};
        word_state <= W_HIGH;
      end
    end
  end

  // Setting has priority over both clearing sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rdy <= 1'b0;
    end else if (byte_rdy && (word_state == W_LOW)) begin
      cmd_rdy <= 1'b1;
    end else if (clr_cmd_rdy || (start_det && (word_state == W_HIGH))) begin
      cmd_rdy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_rx_wrapper.sv
`default_nettype none
// ============================================================================
// tb_cmd_rx_wrapper : table vectors, corner sequences and random frames
// Revision 1.0
// ============================================================================
module tb_cmd_rx_wrapper;

  localparam int B = 32;
  localparam int H = B / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  int errors = 0;
  int checks = 0;
  int frm_cnt = 0;

  cmd_rx_wrapper #(.BAUD_DIV(B), .HALF_DIV(H)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (rx),
    .clr_cmd_rdy (clr),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frm_err) frm_cnt++;

  typedef struct {
    logic [15:0] word;
    bit          glitch;
    bit          bad_pre;
    bit          clr_after;
    logic [15:0] exp_cmd;
    bit          exp_rdy;
    int          exp_frm;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: plain, 1: check set latency around stop mid-sample, 2: clr window over the set
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int mode,
                           input logic [15:0] exp);
    bit seen;
    rx = 1'b0;
    cyc(B);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      cyc(B);
    end
    rx = stop_ok;
    if (mode == 1) begin
      cyc(H + 1);
      chk("pre_set_rdy", cmd_rdy, 1'b0);
      cyc(3);
      chk("lat_rdy", cmd_rdy, 1'b1);
      chk("lat_cmd", cmd, exp);
      cyc(B - H - 4);
    end else if (mode == 2) begin
      cyc(H);
      clr  = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
        cyc(1);
        if (cmd_rdy) seen = 1'b1;
      end
      clr = 1'b0;
      cyc(B - H - 6);
      chk("set_wins", seen, 1'b1);
    end else begin
      cyc(B);
    end
    rx = 1'b1;
    if (!stop_ok) cyc(2 * B);
  endtask

  logic [15:0] prev;
  logic [15:0] m_cmd;
  logic [7:0]  m_hi;
  bit          m_rdy;
  bit          m_have;
  int          f0;

  initial begin
    tbl[0] = '{16'h0001, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 0};
    tbl[1] = '{16'hA5C3, 1'b0, 1'b0, 1'b1, 16'hA5C3, 1'b0, 0};
    tbl[2] = '{16'h1234, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 0};
    tbl[3] = '{16'h00FF, 1'b0, 1'b1, 1'b0, 16'h00FF, 1'b1, 1};
    tbl[4] = '{16'h8E71, 1'b0, 1'b0, 1'b0, 16'h8E71, 1'b1, 0};

    cyc(3);
    chk("reset_cmd", cmd, 16'h0000);
    chk("reset_rdy", cmd_rdy, 1'b0);
    chk("reset_frm", frm_err, 1'b0);
    rst_n = 1'b1;
    cyc(B);

    prev = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      f0 = frm_cnt;
      if (tbl[i].glitch) begin
        rx = 1'b0;
        cyc(H - 6);
        rx = 1'b1;
        cyc(B);
        chk("glitch_cmd", cmd, prev);
        chk("glitch_frm", frm_cnt - f0, 0);
      end
      if (tbl[i].bad_pre) begin
        send_byte(8'h55, 1'b0, 0, 16'h0000);
        chk("bad_frm", frm_cnt - f0, 1);
        chk("bad_cmd", cmd, prev);
        chk("bad_rdy", cmd_rdy, 1'b0);
      end
      send_byte(tbl[i].word[15:8], 1'b1, 0, 16'h0000);
      chk("hi_cmd_hold", cmd, prev);
      chk("hi_rdy", cmd_rdy, 1'b0);
      send_byte(tbl[i].word[7:0], 1'b1, 1, tbl[i].exp_cmd);
      if (tbl[i].clr_after) begin
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
      end
      chk("vec_cmd", cmd, tbl[i].exp_cmd);
      chk("vec_rdy", cmd_rdy, tbl[i].exp_rdy);
      chk("vec_frm", frm_cnt - f0, tbl[i].exp_frm);
      prev = tbl[i].exp_cmd;
      cyc(B);
    end

    // clear asserted across the cycle the second byte completes
    send_byte(8'h3C, 1'b1, 0, 16'h0000);
    send_byte(8'h5A, 1'b1, 2, 16'h0000);
    chk("sw_cmd", cmd, 16'h3C5A);
    chk("sw_rdy_after_clr", cmd_rdy, 1'b0);
    cyc(B);

    // lone high byte, then reset during bit 4 of the next frame
    send_byte(8'h77, 1'b1, 0, 16'h0000);
    rx = 1'b0;
    cyc(B);
    for (int k = 0; k < 4; k++) begin
      rx = k[0];
      cyc(B);
    end
    rx = 1'b1;
    cyc(H);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cmd", cmd, 16'h0000);
    chk("async_rst_rdy", cmd_rdy, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    rx = 1'b1;
    cyc(3 * B);
    f0 = frm_cnt;
    send_byte(8'hBE, 1'b1, 0, 16'h0000);
    chk("rst_hi_rdy", cmd_rdy, 1'b0);
    send_byte(8'hEF, 1'b1, 1, 16'hBEEF);
    chk("rst_cmd", cmd, 16'hBEEF);
    chk("rst_frm", frm_cnt - f0, 0);

    // random frames against a byte-level model
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(B);
    m_cmd = 16'h0000; m_rdy = 1'b0; m_have = 1'b0; m_hi = 8'h00;
    for (int it = 0; it < 30; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        m_rdy = 1'b0;
        chk("rnd_clr_rdy", cmd_rdy, m_rdy);
      end else begin
        logic [7:0] b;
        bit ok;
        b  = 8'($urandom);
        ok = (r != 1);
        f0 = frm_cnt;
        if (!m_have) m_rdy = 1'b0;
        send_byte(b, ok, 0, 16'h0000);
        if (!ok) begin
          m_have = 1'b0;
        end else if (!m_have) begin
          m_hi = b;
          m_have = 1'b1;
        end else begin
          m_cmd = {m_hi, b};
          m_rdy = 1'b1;
          m_have = 1'b0;
        end
        chk("rnd_cmd", cmd, m_cmd);
        chk("rnd_rdy", cmd_rdy, m_rdy);
        chk("rnd_frm", frm_cnt - f0, ok ? 0 : 1);
      end
      cyc($urandom_range(1, B));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
